// File: rtl/mem_stage_if.sv
// Bus between the EX/MEM pipeline register and the data-memory stage.
// The master drives the access request; the slave returns load data and stall.
interface mem_stage_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        misalign;

    modport master (
        output mem_read, mem_write, size, sign_ext, addr, wdata,
        input  mem_rdata, stall, misalign
    );

    modport slave (
        input  mem_read, mem_write, size, sign_ext, addr, wdata,
        output mem_rdata, stall, misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Data-memory stage: byte/half/word loads and stores on a word-addressed RAM with wait states.
// Optional feature macro MEM_MISALIGN_TRAP_EN flags and suppresses misaligned half/word accesses.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_r, state_nx;
    logic [1:0]  cnt_r, cnt_nx;
    logic [31:0] ram_r [DEPTH];

    logic          req_s;
    logic          complete_s;
    logic          stall_s;
    logic          mis_s;
    logic          we_s;
    logic [3:0]    be_s;
    logic [31:0]   wd_s;
    logic [31:0]   word_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [31:0]   load_s;
    logic [AW-1:0] idx_s;
    logic          unused_s;

    assign req_s    = bus.mem_read | bus.mem_write;
    assign idx_s    = bus.addr[AW+1:2];
    assign word_s   = ram_r[idx_s];
    assign unused_s = ^bus.addr[31:AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_s = ((bus.size == 2'b01) && bus.addr[0]) ||
                   (bus.size[1] && (bus.addr[1:0] != 2'b00));
`else
    assign mis_s = 1'b0;
`endif

    // State and wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Next state, stall and completion decode; reset masks every output
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        complete_s = 1'b0;
        stall_s    = 1'b0;
        if (rst) begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!req_s) begin
                        state_nx = IDLE;
                    end else if (WAIT_STATES == 0) begin
                        complete_s = 1'b1;
                    end else begin
                        stall_s  = 1'b1;
                        cnt_nx   = CNT_INIT;
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (!req_s) begin
                        state_nx = IDLE;
                    end else if (cnt_r == 2'd0) begin
                        complete_s = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        stall_s = 1'b1;
                        cnt_nx  = cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 2'd0;
                end
            endcase
        end
    end

    // Lane enables and lane-replicated store data
    always_comb begin
        be_s = 4'b0000;
        wd_s = bus.wdata;
        case (bus.size)
            2'b00: begin
                be_s = 4'b0001 << bus.addr[1:0];
                wd_s = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be_s = bus.addr[1] ? 4'b1100 : 4'b0011;
                wd_s = {2{bus.wdata[15:0]}};
            end
            default: begin
                be_s = 4'b1111;
                wd_s = bus.wdata;
            end
        endcase
    end

    assign we_s = complete_s & bus.mem_write & ~mis_s;

    // Synchronous lane-masked RAM write; contents survive reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_s && be_s[k]) begin
                ram_r[idx_s][8*k +: 8] <= wd_s[8*k +: 8];
            end
        end
    end

    // Lane select and sign/zero extension of the asynchronous read word
    always_comb begin
        byte_s = 8'd0;
        case (bus.addr[1:0])
            2'b00:   byte_s = word_s[7:0];
            2'b01:   byte_s = word_s[15:8];
            2'b10:   byte_s = word_s[23:16];
            default: byte_s = word_s[31:24];
        endcase
        half_s = bus.addr[1] ? word_s[31:16] : word_s[15:0];
        case (bus.size)
            2'b00: begin
                if (bus.sign_ext) begin
                    load_s = {{24{byte_s[7]}}, byte_s};
                end else begin
                    load_s = {24'd0, byte_s};
                end
            end
            2'b01: begin
                if (bus.sign_ext) begin
                    load_s = {{16{half_s[15]}}, half_s};
                end else begin
                    load_s = {16'd0, half_s};
                end
            end
            default: load_s = word_s;
        endcase
    end

    // Output drive; a simultaneous read+write behaves as a store and returns zero
    always_comb begin
        bus.stall    = stall_s;
        bus.misalign = complete_s & mis_s;
        if (complete_s && bus.mem_read && !bus.mem_write && !mis_s) begin
            bus.mem_rdata = load_s;
        end else begin
            bus.mem_rdata = 32'd0;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench: a WAIT_STATES=2 stage and a WAIT_STATES=0 stage share stimulus.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] r_data, b_data, exp_word;
    logic        r_mis, b_stall, exp_mis;
    int          n_stall;

    mem_stage_if ifa ();
    mem_stage_if ifb ();

    assign ifb.mem_read  = ifa.mem_read;
    assign ifb.mem_write = ifa.mem_write;
    assign ifb.size      = ifa.size;
    assign ifb.sign_ext  = ifa.sign_ext;
    assign ifb.addr      = ifa.addr;
    assign ifb.wdata     = ifa.wdata;

    mem_stage #(.DEPTH(256), .WAIT_STATES(2)) dut   (.clk(clk), .rst(rst), .bus(ifa));
    mem_stage #(.DEPTH(256), .WAIT_STATES(0)) dut_0 (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        ifa.mem_read  = 1'b0;
        ifa.mem_write = 1'b0;
        ifa.size      = 2'b10;
        ifa.sign_ext  = 1'b0;
        ifa.addr      = 32'd0;
        ifa.wdata     = 32'd0;
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd);
        logic done;
        done          = 1'b0;
        n_stall       = 0;
        r_data        = 32'd0;
        r_mis         = 1'b0;
        ifa.mem_read  = rd;
        ifa.mem_write = wr;
        ifa.size      = sz;
        ifa.sign_ext  = sx;
        ifa.addr      = a;
        ifa.wdata     = wd;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                b_data  = ifb.mem_rdata;
                b_stall = ifb.stall;
            end
            if (ifa.stall) begin
                n_stall++;
            end else begin
                done   = 1'b1;
                r_data = ifa.mem_rdata;
                r_mis  = ifa.misalign;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        idle_bus();
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ifa.mem_write = 1'b1;
        @(negedge clk);
        check("rst_stall", {31'd0, ifa.stall}, 32'd0);
        check("rst_rdata", ifa.mem_rdata, 32'd0);
        check("rst_misalign", {31'd0, ifa.misalign}, 32'd0);
        @(posedge clk);
        #1;
        idle_bus();
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, ifa.stall}, 32'd0);
        check("idle_rdata", ifa.mem_rdata, 32'd0);
        @(posedge clk);
        #1;

        // word store then load with two wait states
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_stalls", 32'(n_stall), 32'd2);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        check("lw_stalls", 32'(n_stall), 32'd2);
        check("lw_data", r_data, 32'hDEADBEEF);

        // byte lanes and extension
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0);
        check("lb_23", r_data, 32'h00000011);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'd0);
        check("lb_21_sext", r_data, 32'hFFFFFF80);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'd0);
        check("lbu_21", r_data, 32'h00000080);
        access(1'b1, 1'b0, 2'b10, 1'b1, 32'h20, 32'd0);
        check("lw_after_sb", r_data, 32'h11228044);

        // half lanes
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h80001234);
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0);
        check("lh_22", r_data, 32'hFFFF8000);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0);
        check("lhu_22", r_data, 32'h00008000);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h5555ABCD);
        access(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'd0);
        check("lw_after_sh", r_data, 32'h8000ABCD);

        // read+write together acts as a store with zero load data
        access(1'b1, 1'b1, 2'b10, 1'b0, 32'h28, 32'h0BADCAFE);
        check("rw_rdata", r_data, 32'd0);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h28, 32'd0);
        check("rw_stored", r_data, 32'h0BADCAFE);

        // reset during the second stall cycle aborts the store
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
        ifa.mem_write = 1'b1;
        ifa.size      = 2'b10;
        ifa.addr      = 32'h30;
        ifa.wdata     = 32'h00000055;
        @(negedge clk);
        check("rst_abort_stall1", {31'd0, ifa.stall}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_stall2", {31'd0, ifa.stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_bus();
        @(negedge clk);
        check("rst_abort_after", {31'd0, ifa.stall}, 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'd0);
        check("rst_abort_old", r_data, 32'h12345678);

        // flush: request drops while waiting, nothing is written
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h00000000);
        ifa.mem_write = 1'b1;
        ifa.addr      = 32'h50;
        ifa.wdata     = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        check("flush_stall", {31'd0, ifa.stall}, 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'd0);
        check("flush_no_write", r_data, 32'h00000000);

        // address wrap at DEPTH*4 and zero-wait-state timing
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h000, 32'd0);
        check("wrap_lw", r_data, 32'hCAFEF00D);
        check("ws0_stall", {31'd0, b_stall}, 32'd0);
        check("ws0_same_cycle", b_data, 32'hCAFEF00D);

        // misaligned word store
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'hA5A5A5A5);
`ifdef MEM_MISALIGN_TRAP_EN
        exp_mis  = 1'b1;
        exp_word = 32'h11111111;
`else
        exp_mis  = 1'b0;
        exp_word = 32'hA5A5A5A5;
`endif
        check("mis_flag", {31'd0, r_mis}, {31'd0, exp_mis});
        check("mis_stalls", 32'(n_stall), 32'd2);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        check("mis_word40", r_data, exp_word);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
